// File: rtl/pixie_pkg.sv
// pixie_pkg: line timing shared with the Pixie generator, plus the scan doubler FSM encoding.
package pixie_pkg;
  localparam int IN_DIV = 4;
  localparam int ACTIVE_W = 64;
  localparam int IN_HSTART = 16;
  localparam int LINE_PIX = 112;
  localparam int HS_START = 4;
  localparam int HS_LEN = 16;
  localparam logic [23:0] FG_RGB = 24'hFFFFFF;
  localparam logic [23:0] BG_RGB = 24'h000000;
  localparam int XW = $clog2(ACTIVE_W);
  localparam int HW = $clog2(LINE_PIX);
  localparam int PW = $clog2(IN_DIV / 2);
  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_e;
endpackage

// File: rtl/pixie_line_buffer.sv
// pixie_line_buffer: 2 x ACTIVE_W x 1 ping-pong line RAM, one write port, one registered read port.
module pixie_line_buffer
  import pixie_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic          wr_buf_i,
  input  logic [XW-1:0] wr_x_i,
  input  logic          wr_bit_i,
  input  logic          rd_sel_i,
  input  logic [XW-1:0] rd_x_i,
  output logic          rd_bit_o
);
  logic [2*ACTIVE_W-1:0] mem_q;
  logic rd_bit_q;
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[{wr_buf_i, wr_x_i}] <= wr_bit_i;
    rd_bit_q <= mem_q[{rd_sel_i, rd_x_i}];
  end
  assign rd_bit_o = rd_bit_q;
endmodule

// File: rtl/pixie_scan_doubler.sv
// pixie_scan_doubler: captures Pixie lines and replays each twice at double rate; PIXIE_SCANLINES_EN dims the second copy.
module pixie_scan_doubler
  import pixie_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_ce,
  input  logic       in_video,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_hblank,
  input  logic       in_vblank,
  output logic       out_ce,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_video,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_hblank,
  output logic       out_vblank,
  output logic       out_de
);
  logic [XW-1:0] wr_x_q;
  logic wr_buf_q, rd_buf_q, rd_sel_q, pending_q, de_prev_q, hs_prev_q;
  logic [PW-1:0] ph_q;
  logic [HW-1:0] out_h_q;
  state_e state_q, state_d;
  logic in_de, commit, hs_rise, take, wrap, win, hs_win, de_n, rd_bit;
  logic [XW-1:0] rd_x;
  logic [23:0] rgb_c, rgb_s;

  assign in_de   = ~(in_hblank | in_vblank);
  assign commit  = in_ce & de_prev_q & ~in_de;
  assign hs_rise = in_hsync & ~hs_prev_q;
  assign take    = hs_rise & pending_q;
  assign out_ce  = ph_q == PW'(IN_DIV / 2 - 1);
  assign wrap    = out_ce & (out_h_q == HW'(LINE_PIX - 1));
  assign win     = out_h_q >= HW'(IN_HSTART) && out_h_q < HW'(IN_HSTART + ACTIVE_W);
  assign hs_win  = out_h_q >= HW'(HS_START) && out_h_q < HW'(HS_START + HS_LEN);
  assign rd_x    = XW'(out_h_q - HW'(IN_HSTART));

  pixie_line_buffer u_buf (
    .clk      (clk),
    .wr_en_i  (in_ce & in_de),
    .wr_buf_i (wr_buf_q),
    .wr_x_i   (wr_x_q),
    .wr_bit_i (in_video),
    .rd_sel_i (rd_sel_q),
    .rd_x_i   (rd_x),
    .rd_bit_o (rd_bit)
  );

  // A new line with a pending buffer always restarts the first copy, even mid-replay.
  always_comb begin
    state_d = state_q;
    state_d = take ? SHOW_A : wrap ? (state_q == SHOW_A ? SHOW_B : IDLE) : state_q;
  end

  always_comb begin
    de_n  = win & (state_q != IDLE);
    rgb_c = de_n ? (rd_bit ? FG_RGB : BG_RGB) : 24'h0;
`ifdef PIXIE_SCANLINES_EN
    rgb_s = (state_q == SHOW_B) ? (rgb_c >> 1) & 24'h7F7F7F : rgb_c;
`else
    rgb_s = rgb_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_x_q     <= '0;
      wr_buf_q   <= 1'b0;
      rd_buf_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      pending_q  <= 1'b0;
      de_prev_q  <= 1'b0;
      hs_prev_q  <= 1'b0;
      ph_q       <= '0;
      out_h_q    <= '0;
      state_q    <= IDLE;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_video  <= 1'b0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_hblank <= 1'b1;
      out_vblank <= 1'b1;
      out_de     <= 1'b0;
    end else begin
      hs_prev_q <= in_hsync;
      if (in_ce) begin
        de_prev_q <= in_de;
        if (commit) begin
          rd_buf_q <= wr_buf_q;
          wr_buf_q <= ~wr_buf_q;
          wr_x_q   <= '0;
        end else if (in_de && wr_x_q != XW'(ACTIVE_W - 1)) begin
          wr_x_q <= wr_x_q + XW'(1);
        end
      end
      pending_q <= commit | (pending_q & ~take);
      if (take) rd_sel_q <= rd_buf_q;
      ph_q    <= (hs_rise || out_ce) ? '0 : ph_q + PW'(1);
      out_h_q <= (hs_rise || wrap) ? '0 : out_h_q + HW'(out_ce);
      state_q <= state_d;
      if (out_ce) begin
        {out_r, out_g, out_b} <= rgb_s;
        out_video  <= de_n & rd_bit;
        out_hsync  <= hs_win;
        out_vsync  <= in_vsync;
        out_hblank <= ~win;
        out_vblank <= state_q == IDLE;
        out_de     <= de_n;
      end
    end
  end
endmodule
